// File: rtl/hub75_scan_ctrl_pkg.sv
// Shared HUB75 scan types: FSM state encoding, default panel geometry, address-width helper.
package hub75_pkg;

    localparam int DEF_COLS = 64;
    localparam int DEF_ROWS = 32;
    localparam int DEF_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        LATCH,
        DISPLAY,
        ROW_ADV
    } scan_state_e;

    // Never returns zero, so a single-entry dimension still yields a legal 1-bit bus.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hub75_scan_ctrl_if.sv
// Scan-controller bundle: enable/swap handshake, pixel-fetch address and panel pins.
// master = controller driving the panel, slave = fetch/panel side observing it.
interface hub75_scan_ctrl_if #(
    parameter int CW = 6,
    parameter int RW = 5,
    parameter int PW = 3
);
    logic          en;
    logic          swap_req;
    logic          swap_ack;
    logic          buf_sel;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [PW-1:0] plane;
    logic          clk_out;
    logic          lat;
    logic          blank;
    logic          row_clk;
    logic          row_data;
    logic          frame_start;

    modport master (
        input  en, swap_req,
        output swap_ack, buf_sel, col, row, plane,
               clk_out, lat, blank, row_clk, row_data, frame_start
    );

    modport slave (
        output en, swap_req,
        input  swap_ack, buf_sel, col, row, plane,
               clk_out, lat, blank, row_clk, row_data, frame_start
    );
endinterface

// File: rtl/hub75_scan_ctrl_bcm_timer.sv
// BCM on-time down-counter: load BASE_ON<<plane, count down while run, done on the last cycle.
// Latency: done is combinational from the count register; the count spans exactly the loaded value.
// Backpressure: none; run is owned by the scan FSM.
module hub75_bcm_timer #(
    parameter int BASE_ON = 4,
    parameter int BITS    = 8,
    parameter int PW      = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [PW-1:0] plane,
    input  logic          run,
    output logic          done
);
    localparam int TW = $clog2(BASE_ON << (BITS - 1)) + 1;

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = TW'(BASE_ON) << plane;
        end else if (run && (cnt_q != '0)) begin
            cnt_d = cnt_q - TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = run && (cnt_q == TW'(1));

endmodule

// File: rtl/hub75_scan_ctrl.sv
// HUB75 scan controller: shift/latch/BCM-display per plane, row advance, frame-boundary buffer swap.
// Latency: all outputs registered; HUB75_GHOST_BLANK_EN adds GHOST_CYCLES of dead time before row_clk.
// Backpressure: en and swap_req are honoured only at the row-advance exit; never stalls mid-row.
module hub75_scan_ctrl
    import hub75_pkg::*;
#(
    parameter int COLS         = DEF_COLS,
    parameter int ROWS         = DEF_ROWS,
    parameter int BITS         = DEF_BITS,
    parameter int BASE_ON      = 4,
    parameter int GHOST_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     swap_req,
    output logic                     swap_ack,
    output logic                     buf_sel,
    output logic [addr_w(COLS)-1:0]  col,
    output logic [addr_w(ROWS)-1:0]  row,
    output logic [addr_w(BITS)-1:0]  plane,
    output logic                     clk_out,
    output logic                     lat,
    output logic                     blank,
    output logic                     row_clk,
    output logic                     row_data,
    output logic                     frame_start
);
    localparam int CW = addr_w(COLS);
    localparam int RW = addr_w(ROWS);
    localparam int PW = addr_w(BITS);
`ifdef HUB75_GHOST_BLANK_EN
    localparam int PULSE_IDX = GHOST_CYCLES;
`else
    localparam int PULSE_IDX = 0;
`endif
    localparam int AW = addr_w(GHOST_CYCLES + 2) + 1;

    scan_state_e   state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [PW-1:0] plane_q, plane_d;
    logic [AW-1:0] adv_q, adv_d;
    logic          buf_sel_q, buf_sel_d;
    logic          pend_q, pend_d;
    logic          fs_pend_q, fs_pend_d;
    logic          clk_out_q, clk_out_d;
    logic          lat_q, lat_d;
    logic          blank_q, blank_d;
    logic          row_clk_q, row_clk_d;
    logic          row_data_q, row_data_d;
    logic          swap_ack_q, swap_ack_d;
    logic          frame_start_q, frame_start_d;

    logic          tmr_load, tmr_run, tmr_done;
    logic [RW-1:0] next_row;
    logic          row_wrap;

    assign tmr_load = (state_q == LATCH);
    assign tmr_run  = (state_q == DISPLAY);
    assign row_wrap = (row_q == RW'(ROWS - 1));
    assign next_row = row_wrap ? '0 : row_q + RW'(1);

    hub75_bcm_timer #(
        .BASE_ON (BASE_ON),
        .BITS    (BITS),
        .PW      (PW)
    ) u_bcm_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (tmr_load),
        .plane (plane_q),
        .run   (tmr_run),
        .done  (tmr_done)
    );

    // Outputs are computed for the state being entered, so each pin is a flop aligned with state_q.
    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        row_d         = row_q;
        plane_d       = plane_q;
        adv_d         = adv_q;
        buf_sel_d     = buf_sel_q;
        pend_d        = pend_q | swap_req;
        fs_pend_d     = fs_pend_q;
        clk_out_d     = 1'b0;
        lat_d         = 1'b0;
        blank_d       = 1'b1;
        row_clk_d     = 1'b0;
        row_data_d    = 1'b0;
        swap_ack_d    = 1'b0;
        frame_start_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (en) begin
                    state_d       = SHIFT;
                    col_d         = '0;
                    plane_d       = '0;
                    frame_start_d = fs_pend_q;
                    fs_pend_d     = 1'b0;
                end
            end
            SHIFT: begin
                if (!clk_out_q) begin
                    clk_out_d = 1'b1;
                end else if (col_q == CW'(COLS - 1)) begin
                    state_d = LATCH;
                    lat_d   = 1'b1;
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
            LATCH: begin
                state_d = DISPLAY;
                blank_d = 1'b0;
            end
            DISPLAY: begin
                if (!tmr_done) begin
                    blank_d = 1'b0;
                end else if (plane_q != PW'(BITS - 1)) begin
                    state_d = SHIFT;
                    plane_d = plane_q + PW'(1);
                    col_d   = '0;
                end else begin
                    state_d    = ROW_ADV;
                    plane_d    = '0;
                    adv_d      = '0;
                    row_clk_d  = (PULSE_IDX == 0);
                    row_data_d = (PULSE_IDX == 0) && row_wrap;
                end
            end
            ROW_ADV: begin
                if (adv_q == AW'(PULSE_IDX + 1)) begin
                    row_d = next_row;
                    col_d = '0;
                    if (en) begin
                        state_d       = SHIFT;
                        frame_start_d = row_wrap;
                    end else begin
                        state_d   = IDLE;
                        fs_pend_d = row_wrap;
                    end
                end else begin
                    adv_d      = adv_q + AW'(1);
                    row_clk_d  = ((adv_q + AW'(1)) == AW'(PULSE_IDX));
                    row_data_d = ((adv_q + AW'(1)) == AW'(PULSE_IDX)) && row_wrap;
                end
                // Decided one cycle early so the registered ack lands on the exit cycle.
                if ((adv_q == AW'(PULSE_IDX)) && row_wrap && (pend_q || swap_req)) begin
                    swap_ack_d = 1'b1;
                    buf_sel_d  = ~buf_sel_q;
                    pend_d     = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            col_q         <= '0;
            row_q         <= '0;
            plane_q       <= '0;
            adv_q         <= '0;
            buf_sel_q     <= 1'b0;
            pend_q        <= 1'b0;
            fs_pend_q     <= 1'b1;
            clk_out_q     <= 1'b0;
            lat_q         <= 1'b0;
            blank_q       <= 1'b1;
            row_clk_q     <= 1'b0;
            row_data_q    <= 1'b0;
            swap_ack_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            row_q         <= row_d;
            plane_q       <= plane_d;
            adv_q         <= adv_d;
            buf_sel_q     <= buf_sel_d;
            pend_q        <= pend_d;
            fs_pend_q     <= fs_pend_d;
            clk_out_q     <= clk_out_d;
            lat_q         <= lat_d;
            blank_q       <= blank_d;
            row_clk_q     <= row_clk_d;
            row_data_q    <= row_data_d;
            swap_ack_q    <= swap_ack_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign swap_ack    = swap_ack_q;
    assign buf_sel     = buf_sel_q;
    assign col         = col_q;
    assign row         = row_q;
    assign plane       = plane_q;
    assign clk_out     = clk_out_q;
    assign lat         = lat_q;
    assign blank       = blank_q;
    assign row_clk     = row_clk_q;
    assign row_data    = row_data_q;
    assign frame_start = frame_start_q;

endmodule

// File: doc/hub75_scan_ctrl.md
HUB75_SCAN_CTRL -- requirements
Module: hub75_scan_ctrl

Interface
REQ-001 Parameter COLS, default 64, columns shifted per row per plane.
REQ-002 Parameter ROWS, default 32, scan rows per frame.
REQ-003 Parameter BITS, default 8, BCM bitplanes per row.
REQ-004 Parameter BASE_ON, default 4, blank-low cycles for plane 0.
REQ-005 Parameter GHOST_CYCLES, default 4, dead-time cycles before row advance; used only when HUB75_GHOST_BLANK_EN is defined.
REQ-006 Port list SHALL be, in order:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  scan enable.
- swap_req  in  1  level; upstream requests a framebuffer swap.
- swap_ack  out  1  one-cycle pulse; swap taken.
- buf_sel  out  1  framebuffer currently displayed.
- col  out  clog2(COLS)  column address to pixel fetch.
- row  out  clog2(ROWS)  row address to pixel fetch.
- plane  out  clog2(BITS)  bitplane address to pixel fetch.
- clk_out  out  1  panel shift clock.
- lat  out  1  panel latch.
- blank  out  1  panel output-enable, high = dark.
- row_clk  out  1  row shift-register clock.
- row_data  out  1  row shift-register data.
- frame_start  out  1  one-cycle pulse at row 0, plane 0 start.

Function
REQ-007 FSM states SHALL be IDLE, SHIFT, LATCH, DISPLAY, ROW_ADV; all outputs registered.
REQ-008 IDLE: blank=1, clk_out=0, lat=0; leave to SHIFT when en=1.
REQ-009 SHIFT: 2*COLS cycles; pair k presents col=k with clk_out=0, then clk_out=1; blank=1 throughout; after last pair goto LATCH.
REQ-010 LATCH: exactly one cycle, lat=1, blank=1, clk_out=0; then DISPLAY.
REQ-011 DISPLAY: blank=0 for exactly BASE_ON<<plane cycles; counter width clog2(BASE_ON<<(BITS-1))+1, no overflow.
REQ-012 After DISPLAY with plane<BITS-1: plane increments, goto SHIFT.
REQ-013 After DISPLAY with plane=BITS-1: plane wraps to 0, goto ROW_ADV.
REQ-014 ROW_ADV: blank=1, row_clk high one cycle then low one cycle; row_data=1 during the pulse only if next row is 0; row increments, wrapping ROWS-1 to 0.
REQ-015 On wrap to row 0: frame_start pulses on first SHIFT cycle; if swap_req=1 at the ROW_ADV exit cycle, swap_ack pulses that cycle and buf_sel toggles.
REQ-016 swap_req asserted mid-frame SHALL be held pending until the frame boundary; no mid-frame buf_sel change.
REQ-017 en deasserted SHALL take effect only at ROW_ADV exit: goto IDLE, blank=1; resume restarts at the current row, plane 0.
REQ-018 lat and clk_out=1 SHALL never be high in the same cycle; blank SHALL be 1 whenever lat=1 or row_clk=1.

Reset
REQ-019 rst=1 SHALL force next cycle: state IDLE, col=row=plane=0, blank=1, clk_out=lat=row_clk=row_data=0, swap_ack=frame_start=0, buf_sel=0.
REQ-020 rst mid-operation SHALL abandon the current shift/display with no further lat or row_clk pulse.
REQ-021 After reset release with en=1, first SHIFT cycle SHALL pulse frame_start.

Configuration
REQ-022 Macro HUB75_GHOST_BLANK_EN defined: ROW_ADV inserts GHOST_CYCLES blank=1 cycles before the row_clk pulse.
REQ-023 Macro undefined: row_clk pulse occurs on the first ROW_ADV cycle; GHOST_CYCLES ignored.

Structure
REQ-024 Package hub75_pkg SHALL hold the FSM state enum and default COLS/ROWS/BITS constants shared with hub75_top.
REQ-025 Sub-module hub75_bcm_timer SHALL implement the DISPLAY down-counter (load BASE_ON<<plane, done pulse).

Verification (COLS=4, ROWS=2, BITS=2, BASE_ON=2, macro undefined unless stated)
REQ-026 Reset release, en=1 -> frame_start one cycle, 4 clk_out rising edges with col 0..3, one lat pulse, blank=0 for 2 cycles.
REQ-027 Plane 1 of same row -> blank=0 exactly 4 cycles; then row_clk pulse with row_data=0, row becomes 1.
REQ-028 Row 1 complete -> row_clk pulse with row_data=1, row=0, frame_start pulses.
REQ-029 swap_req=1 mid row 0 -> swap_ack single pulse at frame wrap, buf_sel 0->1; no earlier change.
REQ-030 en=0 during SHIFT of row 0 -> row completes, then IDLE with blank=1; en=1 resumes at row 1 plane 0.
REQ-031 HUB75_GHOST_BLANK_EN, GHOST_CYCLES=3 -> 3 blank-high cycles between last DISPLAY and row_clk high; rst mid-DISPLAY -> blank=1 next cycle, no lat.
